mm_writeback: RTL and testbench
===============================

MM_WRITEBACK -- requirements
Module: mm_writeback

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving skid FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter LANES, default 16, giving the number of 32-bit lanes per 512-bit word.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports clk and rstn.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 start_valid  input  1  one-cycle pulse that arms a job.
REQ-007 relu_en  input  1  lane ReLU enable, sampled at start_valid.
REQ-008 expected_count  input  16  number of words for the job (N*Co), sampled at start_valid.
REQ-009 in_addr_valid  input  1  upstream matrix-multiply output address valid.
REQ-010 in_addr  input  11  output-buffer address of the word.
REQ-011 in_data_valid  input  1  upstream result word valid.
REQ-012 in_data  input  512  result word, 16 lanes of signed 32-bit.
REQ-013 buf_wr_en  output  1  output-buffer write request.
REQ-014 buf_wr_addr  output  11  write address.
REQ-015 buf_wr_data  output  512  write data.
REQ-016 buf_wr_ready  input  1  buffer accepts the write this cycle.
REQ-017 done  output  1  one-cycle pulse when the job completes.
REQ-018 overflow  output  1  sticky flag: a word was dropped on a full FIFO.
REQ-019 protocol_err  output  1  sticky flag: in_data_valid was high without in_addr_valid.

Function
REQ-020 States SHALL be IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start_valid.
- RUN->DRAIN when accepted words reach expected_count.
- DRAIN->DONE when the FIFO is empty and no write is pending.
- DONE->IDLE after one cycle.
REQ-021 In RUN, a word SHALL be accepted on a cycle with in_data_valid=1 and in_addr_valid=1, pushing {in_addr, processed in_data}.
REQ-022 in_data_valid=1 with in_addr_valid=0 SHALL set protocol_err and push nothing.
REQ-023 With relu_en=1, each lane with bit 31 set SHALL become 0; other lanes pass unchanged. With relu_en=0 the word passes bit-exact.
REQ-024 A push SHALL succeed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Otherwise the word is dropped and overflow is set.
- A dropped word does not increment the accepted count.
REQ-025 buf_wr_en SHALL equal FIFO non-empty; buf_wr_addr and buf_wr_data SHALL present the head entry and stay stable until buf_wr_en&&buf_wr_ready.
REQ-026 Pop SHALL occur exactly on buf_wr_en&&buf_wr_ready.
REQ-027 Latency: a word accepted at cycle t into an empty FIFO SHALL appear on buf_wr_* at t+1.
REQ-028 Write order SHALL equal acceptance order.
REQ-029 expected_count=0 SHALL go RUN->DRAIN->DONE, with done asserted 2 cycles after start_valid.
REQ-030 start_valid outside IDLE SHALL be ignored.
REQ-031 Inputs arriving in IDLE or DONE SHALL be ignored and set no flag.
REQ-032 overflow and protocol_err SHALL clear on an accepted start_valid.
REQ-033 The accepted counter SHALL be 16 bits and SHALL not wrap within a job.

Reset
REQ-034 On rstn low, the block SHALL immediately enter IDLE and empty the FIFO.
- buf_wr_en, done, overflow, protocol_err = 0.
- buf_wr_addr = 0, buf_wr_data = 0.
REQ-035 Reset mid-job SHALL discard all pending words; no write is issued after rstn rises until a new job's words arrive.

Structure
REQ-036 The shared package mm_pkg SHALL hold the address-width (11), data-width (512), lane-width (32) and count-width (16) constants and the writeback state enum.
REQ-037 The FIFO SHALL be the sub-module sync_fifo (parameterised depth and width, full/empty outputs); ReLU and control stay in mm_writeback.

Verification
REQ-038 Tests SHALL run the following scenarios.
- Basic: relu_en=0, expected_count=3, words at addr 5,6,7, buf_wr_ready=1 -> 3 writes in order, bit-exact, one cycle later each; done pulse once.
- ReLU: relu_en=1, lane0=0xFFFFFFFF, lane1=0x00000005 -> written lane0=0, lane1=5.
- Backpressure: buf_wr_ready=0 for 10 cycles, 4 words in -> addr/data held stable, no overflow; after ready=1, 4 writes then done.
- Overflow: ready=0, 5 words pushed -> overflow=1, only the first 4 written, job stays in RUN.
- Errors: data_valid without addr_valid -> protocol_err=1, nothing written. expected_count=0 -> done 2 cycles after start.
- Reset mid-DRAIN with 2 words pending -> buf_wr_en=0 immediately, state IDLE, no writes after release.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared widths and writeback FSM state type for the matrix-multiply output path.
package mm_pkg;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned DATA_W  = 512;
    localparam int unsigned LANE_W  = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } wb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head entry is read combinationally.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;

    // Same index with differing wrap bits means every slot is occupied.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mm_writeback.sv
// Writeback stage: applies optional lane ReLU to result words and streams them into
// the output buffer through a skid FIFO, counting words until the job completes.
module mm_writeback
    import mm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LANES      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_valid,
    input  logic              relu_en,
    input  logic [CNT_W-1:0]  expected_count,
    input  logic              in_addr_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_data_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    input  logic              buf_wr_ready,
    output logic              done,
    output logic              overflow,
    output logic              protocol_err
);

    wb_state_e          state_q;
    logic               relu_q;
    logic [CNT_W-1:0]   expected_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               overflow_q;
    logic               protocol_err_q;

    logic               in_run;
    logic               word_in;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  relu_data;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] lane;
        assign lane = in_data[i*LANE_W +: LANE_W];
        assign relu_data[i*LANE_W +: LANE_W] = (relu_q && lane[LANE_W-1]) ? '0 : lane;
    end

    assign in_run  = (state_q == StRun);
    // The count guard only matters for a zero-length job, whose single RUN cycle takes nothing.
    assign word_in = in_run && in_data_valid && in_addr_valid && (count_q != expected_q);
    assign pop     = buf_wr_en && buf_wr_ready;
    assign push    = word_in && (!fifo_full || pop);
    assign count_d = push ? count_q + CNT_W'(1) : count_q;

    assign fifo_wdata = {in_addr, relu_data};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stale storage is masked so the bus reads zero whenever nothing is pending.
    assign buf_wr_en    = !fifo_empty;
    assign buf_wr_addr  = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1 -: ADDR_W];
    assign buf_wr_data  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
    assign done         = (state_q == StDrain) && fifo_empty;
    assign overflow     = overflow_q;
    assign protocol_err = protocol_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= StIdle;
            relu_q         <= 1'b0;
            expected_q     <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        state_q        <= StRun;
                        relu_q         <= relu_en;
                        expected_q     <= expected_count;
                        count_q        <= '0;
                        overflow_q     <= 1'b0;
                        protocol_err_q <= 1'b0;
                    end
                end
                StRun: begin
                    count_q <= count_d;
                    if (in_data_valid && !in_addr_valid) begin
                        protocol_err_q <= 1'b1;
                    end
                    if (word_in && !push) begin
                        overflow_q <= 1'b1;
                    end
                    if (count_d == expected_q) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (fifo_empty) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_writeback.sv
// Bench for mm_writeback: directed scenarios, ReLU vector table and randomized jobs
// checked every cycle against a queue-based reference model.
module tb_mm_writeback;

    localparam int DEPTH = 4;
    localparam int LANES = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start_valid = 1'b0;
    logic         relu_en = 1'b0;
    logic [15:0]  expected_count = '0;
    logic         in_addr_valid = 1'b0;
    logic [10:0]  in_addr = '0;
    logic         in_data_valid = 1'b0;
    logic [511:0] in_data = '0;
    logic         buf_wr_en;
    logic [10:0]  buf_wr_addr;
    logic [511:0] buf_wr_data;
    logic         buf_wr_ready = 1'b0;
    logic         done;
    logic         overflow;
    logic         protocol_err;

    always #5 clk = ~clk;

    mm_writeback #(
        .FIFO_DEPTH (DEPTH),
        .LANES      (LANES)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start_valid    (start_valid),
        .relu_en        (relu_en),
        .expected_count (expected_count),
        .in_addr_valid  (in_addr_valid),
        .in_addr        (in_addr),
        .in_data_valid  (in_data_valid),
        .in_data        (in_data),
        .buf_wr_en      (buf_wr_en),
        .buf_wr_addr    (buf_wr_addr),
        .buf_wr_data    (buf_wr_data),
        .buf_wr_ready   (buf_wr_ready),
        .done           (done),
        .overflow       (overflow),
        .protocol_err   (protocol_err)
    );

    typedef struct packed {
        logic [10:0]  addr;
        logic [511:0] data;
    } wr_t;

    typedef struct {
        bit          relu;
        logic [31:0] lane_in;
        logic [31:0] lane_out;
    } relu_vec_t;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;

    // Reference model: job phase 0 idle, 1 collecting, 2 draining, 3 finished.
    wr_t mq[$];
    int  m_phase = 0;
    int  m_cnt = 0;
    int  m_exp = 0;
    bit  m_relu = 1'b0;
    bit  m_ovf = 1'b0;
    bit  m_perr = 1'b0;
    int  n_writes = 0;

    wr_t obs[$];
    int  obs_cyc[$];
    int  done_cnt = 0;
    int  last_done_cyc = -1;

    always @(negedge clk) begin
        if (buf_wr_en && buf_wr_ready) begin
            obs.push_back({buf_wr_addr, buf_wr_data});
            obs_cyc.push_back(cyc_n);
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc_n;
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [511:0] ref_relu(input bit en, input logic [511:0] d);
        logic [511:0] r;
        r = d;
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if ($signed(d[i*32 +: 32]) < 0) r[i*32 +: 32] = 32'h0;
            end
        end
        return r;
    endfunction

    function automatic logic [511:0] rand_word();
        logic [511:0] r;
        for (int i = 0; i < LANES; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    // Drive one cycle of inputs, compare outputs against the model, advance both.
    task automatic cyc(input bit sv, input bit re, input logic [15:0] ec, input bit av,
                       input logic [10:0] a, input bit dv, input logic [511:0] d,
                       input bit rdy);
        bit pop;
        bit push;
        int nph;
        start_valid = sv;
        relu_en = re;
        expected_count = ec;
        in_addr_valid = av;
        in_addr = a;
        in_data_valid = dv;
        in_data = d;
        buf_wr_ready = rdy;
        chk("wr_en", buf_wr_en, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("wr_addr", buf_wr_addr, mq[0].addr);
            chk("wr_data", buf_wr_data, mq[0].data);
        end else begin
            chk("wr_addr_idle", buf_wr_addr, 0);
            chk("wr_data_idle", buf_wr_data, 0);
        end
        chk("done", done, (m_phase == 2) && (mq.size() == 0));
        chk("overflow", overflow, m_ovf);
        chk("protocol_err", protocol_err, m_perr);

        pop = (mq.size() != 0) && rdy;
        push = 1'b0;
        nph = m_phase;
        case (m_phase)
            0: if (sv) begin
                nph = 1;
                m_relu = re;
                m_exp = int'(ec);
                m_cnt = 0;
                m_ovf = 1'b0;
                m_perr = 1'b0;
            end
            1: begin
                if (dv && !av) m_perr = 1'b1;
                if (dv && av && m_cnt < m_exp) begin
                    if (mq.size() < DEPTH || pop) push = 1'b1;
                    else m_ovf = 1'b1;
                end
                if (push) m_cnt++;
                if (m_cnt == m_exp) nph = 2;
            end
            2: if (mq.size() == 0) nph = 3;
            default: nph = 0;
        endcase
        if (pop) begin
            void'(mq.pop_front());
            n_writes++;
        end
        if (push) mq.push_back({a, ref_relu(m_relu, d)});
        m_phase = nph;
        tick();
    endtask

    task automatic start(input bit re, input logic [15:0] ec, input bit rdy);
        cyc(1'b1, re, ec, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic word(input logic [10:0] a, input logic [511:0] d, input bit rdy);
        cyc(1'b0, 1'b0, '0, 1'b1, a, 1'b1, d, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (m_phase != 0 && n < bound) begin
            cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
            n++;
        end
        if (m_phase != 0) fail_now("wait_idle");
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        start_valid = 1'b0;
        in_addr_valid = 1'b0;
        in_data_valid = 1'b0;
        buf_wr_ready = 1'b0;
        #1;
        chk("rst_wr_en", buf_wr_en, 0);
        chk("rst_wr_addr", buf_wr_addr, 0);
        chk("rst_wr_data", buf_wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_protocol_err", protocol_err, 0);
        mq.delete();
        m_phase = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_perr = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    relu_vec_t    vecs[8];
    wr_t          w [8];
    int           base_w;
    int           base_d;
    int           t0;
    int           s;
    int           n;
    bit           dv;
    bit           av;
    logic [511:0] d;

    initial begin
        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0005};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{1'b1, 32'hDEAD_BEEF, 32'h0000_0000};

        do_reset();
        idle(2, 1'b1);

        // Words and protocol errors while idle are ignored.
        base_w = obs.size();
        cyc(1'b0, 1'b0, '0, 1'b1, 11'd9, 1'b1, rand_word(), 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 11'd9, 1'b1, rand_word(), 1'b1);
        idle(2, 1'b1);
        chk("idle_no_write", obs.size() - base_w, 0);
        chk("idle_no_perr", protocol_err, 0);

        // Basic: three words, bit-exact, one cycle latency, single done.
        base_w = obs.size();
        base_d = done_cnt;
        start(1'b0, 16'd3, 1'b1);
        t0 = cyc_n;
        for (int i = 0; i < 3; i++) begin
            w[i] = {11'(5 + i), rand_word()};
            word(w[i].addr, w[i].data, 1'b1);
        end
        wait_idle(20);
        chk("basic_nwr", obs.size() - base_w, 3);
        if (obs.size() - base_w == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("basic_addr", obs[base_w + i].addr, w[i].addr);
                chk("basic_data", obs[base_w + i].data, w[i].data);
                chk("basic_latency", obs_cyc[base_w + i], t0 + i + 1);
            end
        end
        chk("basic_done_once", done_cnt - base_d, 1);

        // ReLU: negative lane cleared, positive lane kept.
        start(1'b1, 16'd1, 1'b1);
        d = rand_word();
        d[31:0] = 32'hFFFF_FFFF;
        d[63:32] = 32'h0000_0005;
        word(11'd12, d, 1'b1);
        wait_idle(20);
        chk("relu_lane0", obs[obs.size() - 1].data[31:0], 32'h0);
        chk("relu_lane1", obs[obs.size() - 1].data[63:32], 32'h5);

        for (int k = 0; k < 8; k++) begin
            start(vecs[k].relu, 16'd1, 1'b1);
            word(11'(100 + k), {16{vecs[k].lane_in}}, 1'b1);
            wait_idle(20);
            chk("relu_vec", obs[obs.size() - 1].data, {16{vecs[k].lane_out}});
        end

        // Backpressure: four words held for ten cycles, head stays put, no overflow.
        base_w = obs.size();
        base_d = done_cnt;
        start(1'b0, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w[i] = {11'(20 + i), rand_word()};
            word(w[i].addr, w[i].data, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            chk("bp_hold_addr", buf_wr_addr, w[0].addr);
            chk("bp_hold_data", buf_wr_data, w[0].data);
            idle(1, 1'b0);
        end
        chk("bp_no_overflow", overflow, 0);
        chk("bp_no_write", obs.size() - base_w, 0);
        wait_idle(20);
        chk("bp_nwr", obs.size() - base_w, 4);
        if (obs.size() - base_w == 4) begin
            for (int i = 0; i < 4; i++) chk("bp_order", obs[base_w + i].addr, w[i].addr);
        end
        chk("bp_done_once", done_cnt - base_d, 1);

        // Overflow: fifth word dropped and not counted, job stays open.
        base_w = obs.size();
        base_d = done_cnt;
        start(1'b0, 16'd6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            w[i] = {11'(40 + i), rand_word()};
            word(w[i].addr, w[i].data, 1'b0);
        end
        chk("ovf_flag", overflow, 1);
        idle(6, 1'b1);
        chk("ovf_nwr", obs.size() - base_w, 4);
        chk("ovf_still_run", done_cnt - base_d, 0);
        if (obs.size() - base_w == 4) begin
            for (int i = 0; i < 4; i++) chk("ovf_order", obs[base_w + i].addr, w[i].addr);
        end
        word(11'd45, rand_word(), 1'b1);
        word(11'd46, rand_word(), 1'b1);
        wait_idle(20);
        chk("ovf_final_nwr", obs.size() - base_w, 6);
        chk("ovf_last_addr", obs[obs.size() - 1].addr, 11'd46);
        chk("ovf_done_once", done_cnt - base_d, 1);
        chk("ovf_sticky", overflow, 1);

        // Protocol error: data without address writes nothing.
        base_w = obs.size();
        start(1'b0, 16'd1, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 11'd3, 1'b1, rand_word(), 1'b1);
        idle(3, 1'b1);
        chk("perr_flag", protocol_err, 1);
        chk("perr_no_write", obs.size() - base_w, 0);
        word(11'd77, rand_word(), 1'b1);
        wait_idle(20);
        chk("perr_nwr", obs.size() - base_w, 1);

        // Zero-length job: done two cycles after start, flags cleared by the start.
        base_d = done_cnt;
        s = cyc_n;
        start(1'b0, 16'd0, 1'b1);
        chk("zero_perr_clear", protocol_err, 0);
        wait_idle(10);
        chk("zero_done_cycle", last_done_cyc, s + 2);
        chk("zero_done_once", done_cnt - base_d, 1);

        // Reset during drain with two words pending.
        start(1'b0, 16'd2, 1'b0);
        word(11'd60, rand_word(), 1'b0);
        word(11'd61, rand_word(), 1'b0);
        idle(1, 1'b0);
        chk("rd_pending", buf_wr_en, 1);
        base_w = obs.size();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b1, 11'd62, 1'b1, rand_word(), 1'b1);
        end
        chk("rd_no_write", obs.size() - base_w, 0);
        start(1'b0, 16'd1, 1'b1);
        word(11'd63, rand_word(), 1'b1);
        wait_idle(20);
        chk("rd_new_job", obs.size() - base_w, 1);

        // Randomized jobs against the model.
        for (int j = 0; j < 40; j++) begin
            start(1'($urandom), 16'($urandom_range(0, 10)), 1'($urandom));
            n = 0;
            while (m_phase != 0 && n < 400) begin
                dv = ($urandom % 100) < 55;
                av = dv ? (($urandom % 100) < 93) : 1'($urandom);
                cyc(($urandom % 8) == 0, 1'($urandom), 16'($urandom), av, 11'($urandom), dv,
                    rand_word(), ($urandom % 100) < 65);
                n++;
            end
            if (m_phase != 0) fail_now("rand_job");
            for (int i = 0; i < 2; i++) begin
                cyc(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), 11'($urandom),
                    1'($urandom), rand_word(), 1'($urandom));
            end
        end
        chk("total_writes", obs.size(), n_writes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
